// File: rtl/decode_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_queue : first-word-fall-through entry queue between IF and EXE,
//                with single-cycle flush and count-based full/empty.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module decode_queue #(
   parameter  int DEPTH   = 4,
   parameter  int DATA_WD = 64,
   localparam int PTR_WD  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               in_valid,
   input  logic [DATA_WD-1:0] in_bus,
   output logic               in_allow,
   input  logic               ready_go,
   input  logic               out_allow,
   output logic               out_valid,
   output logic [DATA_WD-1:0] out_bus,
   input  logic               flush,
   output logic [PTR_WD:0]    count,
   output logic               full,
   output logic               empty
);

   localparam logic [PTR_WD:0]   CNT_FULL = (PTR_WD+1)'(DEPTH);
   localparam logic [PTR_WD:0]   CNT_ONE  = (PTR_WD+1)'(1);
   localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);

   logic [DATA_WD-1:0] mem_q [DEPTH];
   logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WD:0]    count_q,  count_d;
   logic               push;
   logic               pop;

   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign count     = count_q;

   // Handshakes deliberately ignore flush; the redirect is gated downstream.
   assign out_valid = ~empty & ready_go;
   assign pop       = out_valid & out_allow;
   assign in_allow  = ~full | pop;
   assign push      = in_valid & in_allow;
   assign out_bus   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale contents are never presented as valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= in_bus;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// Scoreboard bench for decode_queue (DEPTH=4, DATA_WD=64): stimulus pushes
// expected entries, a negedge monitor pops and compares on every handshake.
module tb_decode_queue;

   localparam int DEPTH   = 4;
   localparam int DATA_WD = 64;
   localparam int PTR_WD  = $clog2(DEPTH);

   logic               clk = 1'b0;
   logic               resetn;
   logic               in_valid;
   logic [DATA_WD-1:0] in_bus;
   logic               in_allow;
   logic               ready_go;
   logic               out_allow;
   logic               out_valid;
   logic [DATA_WD-1:0] out_bus;
   logic               flush;
   logic [PTR_WD:0]    count;
   logic               full;
   logic               empty;

   int errors = 0;
   int checks = 0;
   logic [DATA_WD-1:0] exp_q [$];

   decode_queue #(.DEPTH(DEPTH), .DATA_WD(DATA_WD)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_bus    (in_bus),
      .in_allow  (in_allow),
      .ready_go  (ready_go),
      .out_allow (out_allow),
      .out_valid (out_valid),
      .out_bus   (out_bus),
      .flush     (flush),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [63:0] d);
      in_valid = 1'b1;
      in_bus   = d;
      exp_q.push_back(d);
   endtask

   // Monitor: every accepted output must match the oldest expected entry.
   always @(negedge clk) begin
      if (resetn && out_valid && out_allow) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %h expected none", out_bus);
         end else begin
            chk("pop_data", out_bus, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_bus    = '0;
      ready_go  = 1'b1;
      out_allow = 1'b0;
      flush     = 1'b0;
      #1;
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_empty",     64'(empty),     64'd1);
      chk("rst_full",      64'(full),      64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_allow",  64'(in_allow),  64'd1);
      step();
      resetn = 1'b1;

      // Fill to full with downstream stalled.
      offer(64'h0000_0004_AAAA_0001); step(); chk("fill_cnt1", 64'(count), 64'd1);
      offer(64'h0000_0008_BBBB_0002); step(); chk("fill_cnt2", 64'(count), 64'd2);
      offer(64'h0000_000C_CCCC_0003); step(); chk("fill_cnt3", 64'(count), 64'd3);
      offer(64'h0000_0010_DDDD_0004); step(); chk("fill_cnt4", 64'(count), 64'd4);
      in_valid = 1'b0;
      #1;
      chk("fill_full",     64'(full),     64'd1);
      chk("fill_in_allow", 64'(in_allow), 64'd0);
      chk("fill_head",     out_bus,       64'h0000_0004_AAAA_0001);

      // Push and pop together while full.
      offer(64'h0000_0014_EEEE_0005);
      out_allow = 1'b1;
      #1;
      chk("full_pp_in_allow", 64'(in_allow), 64'd1);
      step();
      chk("full_pp_count", 64'(count), 64'd4);
      in_valid = 1'b0;
      repeat (4) step();
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_count", 64'(count), 64'd0);

      // Streaming one per cycle; pointers wrap twice.
      offer(64'h1111_0000_0000_0000);
      step();
      for (int i = 1; i <= 10; i++) begin
         offer(64'h1111_0000_0000_0000 | 64'(i));
         step();
         chk("stream_count", 64'(count), 64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_end_count", 64'(count), 64'd0);

      // Stall unit holds the head.
      out_allow = 1'b0;
      offer(64'h2222_0000_0000_00A0); step();
      offer(64'h2222_0000_0000_00A1); step();
      in_valid  = 1'b0;
      ready_go  = 1'b0;
      out_allow = 1'b1;
      #1;
      chk("stall_out_valid", 64'(out_valid), 64'd0);
      step(); step();
      chk("stall_count", 64'(count), 64'd2);
      chk("stall_head",  out_bus,    64'h2222_0000_0000_00A0);
      ready_go = 1'b1;
      #1;
      chk("go_out_valid", 64'(out_valid), 64'd1);
      step();
      chk("go_count1", 64'(count), 64'd1);
      step();
      chk("go_count0", 64'(count), 64'd0);

      // Flush with a simultaneous push: nothing survives.
      out_allow = 1'b0;
      offer(64'h3333_0000_0000_00B0); step();
      offer(64'h3333_0000_0000_00B1); step();
      offer(64'h3333_0000_0000_00B2); step();
      chk("pre_flush_count", 64'(count), 64'd3);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_bus   = 64'h3333_DEAD_0000_00BF;
      #1;
      chk("flush_out_valid_indep", 64'(out_valid), 64'd1);
      chk("flush_in_allow_indep",  64'(in_allow),  64'd1);
      step();
      exp_q.delete();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_count",     64'(count),     64'd0);
      chk("flush_empty",     64'(empty),     64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      out_allow = 1'b1;
      repeat (3) step();
      chk("post_flush_empty", 64'(empty), 64'd1);

      // Asynchronous reset mid-operation.
      out_allow = 1'b0;
      offer(64'h4444_0000_0000_00C0); step();
      offer(64'h4444_0000_0000_00C1); step();
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd2);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_count",    64'(count),    64'd0);
      chk("arst_empty",    64'(empty),    64'd1);
      chk("arst_in_allow", 64'(in_allow), 64'd1);
      exp_q.delete();
      step();
      resetn = 1'b1;
      offer(64'h5555_0000_0000_00D0);
      step();
      in_valid = 1'b0;
      #1;
      chk("rst_x_head",      out_bus,        64'h5555_0000_0000_00D0);
      chk("rst_x_out_valid", 64'(out_valid), 64'd1);
      chk("rst_x_count",     64'(count),     64'd1);
      out_allow = 1'b1;
      step();
      step();
      chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, 2 to 32.
REQ-002 SHALL have parameter DATA_WD, default 64, meaning entry width ({PC_plus_4, inst}).
REQ-003 SHALL derive local parameter PTR_WD = log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  IF offers an entry.
REQ-007 SHALL have port in_bus  input  DATA_WD  offered entry.
REQ-008 SHALL have port in_allow  output  1  queue accepts an entry this cycle.
REQ-009 SHALL have port ready_go  input  1  stall unit permits the head to leave (1 = go).
REQ-010 SHALL have port out_allow  input  1  downstream (EXE) can take an entry.
REQ-011 SHALL have port out_valid  output  1  head entry offered downstream.
REQ-012 SHALL have port out_bus  output  DATA_WD  head entry.
REQ-013 SHALL have port flush  input  1  branch/jump redirect; discard all entries.
REQ-014 SHALL have port count  output  PTR_WD+1  current occupancy.
REQ-015 SHALL have port full  output  1  count == DEPTH.
REQ-016 SHALL have port empty  output  1  count == 0.

Function
REQ-017 SHALL store entries in a DEPTH-deep circular buffer with a write pointer, a read pointer and an occupancy counter.
REQ-018 SHALL define push = in_valid & in_allow, and SHALL define pop = out_valid & out_allow.
REQ-019 SHALL drive in_allow = ~full | pop, so a full queue accepts a new entry in the same cycle it pops one.
REQ-020 SHALL drive out_valid = ~empty & ready_go, combinationally.
REQ-021 SHALL drive out_bus from the head entry combinationally (first-word fall-through).
REQ-022 SHALL make a pushed entry visible on out_valid no earlier than the cycle after the push (1-cycle latency), with no empty-bypass path.
REQ-023 SHALL update count as count+1 on push only, count-1 on pop only, and leave it unchanged on simultaneous push and pop or on neither.
REQ-024 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-025 SHALL, on a cycle with flush=1, clear count and set both pointers to 0 at the next edge, ignoring any push or pop in that cycle.
REQ-026 SHALL give flush priority over push and pop, and SHALL perform no write into the buffer during flush.
REQ-027 SHALL keep in_allow and out_valid combinationally independent of flush; downstream gates the redirect externally.
REQ-028 SHALL hold the head entry and pointers unchanged while ready_go=0 or out_allow=0.
REQ-029 SHALL drive full and empty from count, never from pointer comparison alone.
REQ-030 SHALL not allow overflow or underflow by construction; count SHALL stay within 0 to DEPTH.
REQ-031 SHALL drive out_bus while empty as don't-care, and verification SHALL NOT check it.

Reset
REQ-032 SHALL, while resetn=0, asynchronously set count=0, both pointers=0, empty=1, full=0, out_valid=0, and in_allow=1.
REQ-033 SHALL leave buffer storage unreset.
REQ-034 SHALL, on reset assertion mid-operation, discard all stored entries; the first push after release is the new head.
REQ-035 SHALL release reset synchronously to clk; the first push may occur in the first cycle with resetn=1.

Verification (DEPTH=4, DATA_WD=64)
REQ-036 SHALL cover: fill with out_allow=0 and ready_go=1, push A,B,C,D -> count 1,2,3,4; full=1; in_allow=0; out_bus=A.
REQ-037 SHALL cover: while full, in_valid=1 with E and out_allow=1 in one cycle -> in_allow=1, A pops, E is written, count stays 4; then pops return B,C,D,E in order.
REQ-038 SHALL cover: ten push/pop pairs at one entry per cycle -> pointers wrap twice; output order equals input order; count constant at 1.
REQ-039 SHALL cover: ready_go=0 with 2 entries and out_allow=1 -> out_valid=0, count stays 2, head unchanged; ready_go=1 -> head pops next edge.
REQ-040 SHALL cover: flush=1 with count=3 and simultaneous push -> next cycle count=0, empty=1, out_valid=0; the pushed entry is never output.
REQ-041 SHALL cover: resetn pulsed low asynchronously between edges with count=2 -> count=0 and empty=1 immediately; after release, push X -> out_bus=X next cycle.
